// File: rtl/atm_pkg.sv
// Shared constants, opcodes, status codes and FSM state type for the ATM transaction controller.
package atm_pkg;

  localparam int ACCTS     = 16;
  localparam int BAL_WIDTH = 10;
  localparam int CNT_WIDTH = 8;

  localparam logic [1:0] OP_BAL  = 2'b00;
  localparam logic [1:0] OP_WDR  = 2'b01;
  localparam logic [1:0] OP_XFR  = 2'b10;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam logic [1:0] ST_NOFUNDS = 2'b00;
  localparam logic [1:0] ST_OK      = 2'b01;
  localparam logic [1:0] ST_INVALID = 2'b10;
  localparam logic [1:0] ST_EXIT    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EXEC,
    WR_SRC,
    WR_DST,
    RESP
  } state_e;

  localparam logic [BAL_WIDTH-1:0] INIT_BALANCE [ACCTS] = '{
    10'd214, 10'd502, 10'd237, 10'd109, 10'd250, 10'd234, 10'd213, 10'd504,
    10'd341, 10'd491, 10'd73,  10'd438, 10'd340, 10'd310, 10'd463, 10'd239
  };

endpackage

// File: rtl/atm_balance_bank.sv
// Account balance storage: per-entry registers reset to the initial table,
// two registered read ports and one synchronous write port (read-old on collision).
module atm_balance_bank
  import atm_pkg::*;
#(
  parameter int  N_ACCT = ACCTS,
  parameter int  BAL_W  = BAL_WIDTH,
  localparam int AW     = $clog2(N_ACCT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rd_a_addr,
  input  logic [AW-1:0]    rd_b_addr,
  output logic [BAL_W-1:0] rd_a_data,
  output logic [BAL_W-1:0] rd_b_data,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [BAL_W-1:0] wr_data
);

  logic [BAL_W-1:0] mem_rd [N_ACCT];
  logic [BAL_W-1:0] rd_a_q;
  logic [BAL_W-1:0] rd_b_q;

  generate
    for (genvar gi = 0; gi < N_ACCT; gi++) begin : g_entry
      logic [BAL_W-1:0] entry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= BAL_W'(INIT_BALANCE[gi]);
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          entry_q <= wr_data;
        end
      end

      assign mem_rd[gi] = entry_q;
    end
  endgenerate

  // Reads sample the pre-write contents, so a same-cycle write is not visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= mem_rd[rd_a_addr];
      rd_b_q <= mem_rd[rd_b_addr];
    end
  end

  assign rd_a_data = rd_a_q;
  assign rd_b_data = rd_b_q;

endmodule

// File: rtl/atm_txn_controller.sv
// ATM transaction sequencer: accepts one request, runs read-check-write against
// the balance bank, and returns status and source balance over a valid/ready channel.
module atm_txn_controller
  import atm_pkg::*;
#(
  parameter int  N_ACCT = ACCTS,
  parameter int  BAL_W  = BAL_WIDTH,
  parameter int  CNT_W  = CNT_WIDTH,
  localparam int AW     = $clog2(N_ACCT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_select,
  input  logic [AW-1:0]    req_src,
  input  logic [AW-1:0]    req_dst,
  input  logic [BAL_W-1:0] req_amount,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [1:0]       resp_status,
  output logic [BAL_W-1:0] resp_balance,
  output logic [CNT_W-1:0] txn_count
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [AW-1:0]    src_q, dst_q;
  logic [BAL_W-1:0] amt_q;
  logic [BAL_W-1:0] new_dst_q, new_dst_d;
  logic [1:0]       status_q, status_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [BAL_W-1:0] bal_src, bal_dst;
  logic [BAL_W:0]   dst_sum;
  logic             no_funds;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [BAL_W-1:0] wr_data;

  atm_balance_bank #(
    .N_ACCT (N_ACCT),
    .BAL_W  (BAL_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .rd_a_addr (src_q),
    .rd_b_addr (dst_q),
    .rd_a_data (bal_src),
    .rd_b_data (bal_dst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // One extra bit so a destination overflow past the balance range is visible.
  assign dst_sum  = {1'b0, bal_dst} + {1'b0, amt_q};
  assign no_funds = (amt_q > bal_src);

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    balance_d = balance_q;
    new_dst_d = new_dst_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = RD;
      end
      RD: state_d = EXEC;
      EXEC: begin
        state_d   = RESP;
        balance_d = bal_src;
        new_dst_d = dst_sum[BAL_W-1:0];
        case (op_q)
          OP_BAL: status_d = ST_OK;
          OP_WDR: begin
            if (no_funds) begin
              status_d = ST_NOFUNDS;
            end else begin
              status_d  = ST_OK;
              balance_d = bal_src - amt_q;
              state_d   = WR_SRC;
            end
          end
          OP_XFR: begin
            if (src_q == dst_q) begin
              status_d = ST_INVALID;
            end else if (no_funds) begin
              status_d = ST_NOFUNDS;
            end else if (dst_sum[BAL_W]) begin
              status_d = ST_INVALID;
            end else begin
              status_d  = ST_OK;
              balance_d = bal_src - amt_q;
              state_d   = WR_SRC;
            end
          end
          default: status_d = ST_EXIT;
        endcase
      end
      WR_SRC: state_d = (op_q == OP_XFR) ? WR_DST : RESP;
      WR_DST: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          if (status_q == ST_OK) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_BAL;
      src_q     <= '0;
      dst_q     <= '0;
      amt_q     <= '0;
      new_dst_q <= '0;
      status_q  <= ST_NOFUNDS;
      balance_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      new_dst_q <= new_dst_d;
      status_q  <= status_d;
      balance_q <= balance_d;
      cnt_q     <= cnt_d;
      if ((state_q == IDLE) && req_valid) begin
        op_q  <= req_select;
        src_q <= req_src;
        dst_q <= req_dst;
        amt_q <= req_amount;
      end
    end
  end

  // The response balance already holds the new source balance, so it doubles as write data.
  assign wr_en   = (state_q == WR_SRC) || (state_q == WR_DST);
  assign wr_addr = (state_q == WR_DST) ? dst_q : src_q;
  assign wr_data = (state_q == WR_DST) ? new_dst_q : balance_q;

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == RESP);
  assign resp_status  = status_q;
  assign resp_balance = balance_q;
  assign txn_count    = cnt_q;

endmodule

// File: tb/tb_atm_txn_controller.sv
// Randomized self-checking bench for atm_txn_controller against an account-level reference model.
module tb_atm_txn_controller;
  import atm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_select;
  logic [3:0] req_src;
  logic [3:0] req_dst;
  logic [9:0] req_amount;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_status;
  logic [9:0] resp_balance;
  logic [7:0] txn_count;

  int n_checks = 0;
  int n_pass   = 0;
  int model_bal [16];
  int model_cnt;

  atm_txn_controller dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_select   (req_select),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_amount   (req_amount),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_status  (resp_status),
    .resp_balance (resp_balance),
    .txn_count    (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    int init_vals [16] = '{214, 502, 237, 109, 250, 234, 213, 504,
                           341, 491, 73, 438, 340, 310, 463, 239};
    for (int i = 0; i < 16; i++) model_bal[i] = init_vals[i];
    model_cnt = 0;
  endtask

  // Account-level outcome: status, source balance afterwards, and cycles to response.
  task automatic model_exec(input int op, input int src, input int dst, input int amt,
                            output int st, output int bal, output int lat);
    st  = 1;
    lat = 3;
    case (op)
      0: st = 1;
      1: begin
        if (amt <= model_bal[src]) begin
          model_bal[src] -= amt;
          lat = 4;
        end else st = 0;
      end
      2: begin
        if (src == dst) st = 2;
        else if (amt > model_bal[src]) st = 0;
        else if (model_bal[dst] + amt > 1023) st = 2;
        else begin
          model_bal[src] -= amt;
          model_bal[dst] += amt;
          lat = 5;
        end
      end
      default: st = 3;
    endcase
    bal = model_bal[src];
  endtask

  task automatic run_txn(input int op, input int src, input int dst, input int amt, input int hold);
    int st, bal, lat, obs_lat, k;
    model_exec(op, src, dst, amt, st, bal, lat);
    @(negedge clk);
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before", int'(req_ready), 1);
    req_valid  = 1'b1;
    req_select = 2'(op);
    req_src    = 4'(src);
    req_dst    = 4'(dst);
    req_amount = 10'(amt);
    @(negedge clk);
    req_valid = 1'b0;
    obs_lat = 1;
    while (!resp_valid && obs_lat < 20) begin
      @(negedge clk);
      obs_lat++;
    end
    check("latency", obs_lat, lat);
    check("resp_status", int'(resp_status), st);
    check("resp_balance", int'(resp_balance), bal);
    for (int h = 0; h < hold; h++) begin
      req_valid  = 1'b1;
      req_select = 2'($urandom);
      req_src    = 4'($urandom);
      req_dst    = 4'($urandom);
      req_amount = 10'($urandom);
      @(negedge clk);
      check("hold_resp_valid", int'(resp_valid), 1);
      check("hold_status", int'(resp_status), st);
      check("hold_balance", int'(resp_balance), bal);
      check("hold_req_ready", int'(req_ready), 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (st == 1) model_cnt = (model_cnt + 1) % 256;
    check("txn_count", int'(txn_count), model_cnt);
    check("req_ready_after", int'(req_ready), 1);
    check("resp_valid_after", int'(resp_valid), 0);
    $display("txn op=%0d src=%0d dst=%0d amt=%0d hold=%0d -> status=%0d bal=%0d lat=%0d cnt=%0d",
             op, src, dst, amt, hold, st, bal, obs_lat, model_cnt);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int op, src, dst, amt;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_select = '0;
    req_src    = '0;
    req_dst    = '0;
    req_amount = '0;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_resp_status", int'(resp_status), 0);
    check("rst_resp_balance", int'(resp_balance), 0);
    check("rst_txn_count", int'(txn_count), 0);
    rst = 1'b0;

    run_txn(0, 1, 0, 0, 0);
    run_txn(1, 0, 0, 14, 0);
    run_txn(1, 0, 0, 201, 0);
    run_txn(2, 7, 14, 500, 0);
    run_txn(0, 14, 0, 0, 0);
    run_txn(2, 1, 14, 100, 0);
    run_txn(0, 1, 0, 0, 0);
    run_txn(0, 14, 0, 0, 0);
    run_txn(2, 3, 3, 5, 0);
    run_txn(3, 2, 0, 0, 0);
    run_txn(1, 4, 0, 9, 10);
    run_txn(1, 5, 0, 0, 1);
    run_txn(2, 6, 10, 0, 0);

    for (int t = 0; t < 40; t++) begin
      op  = int'($urandom_range(0, 3));
      src = int'($urandom_range(0, 15));
      dst = ($urandom_range(0, 7) == 0) ? src : int'($urandom_range(0, 15));
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 150));
      run_txn(op, src, dst, amt, int'($urandom_range(0, 3)));
    end

    // Abort a transfer in WR_DST; both accounts must come back from the initial table.
    apply_reset();
    run_txn(0, 1, 0, 0, 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_select = 2'b10;
    req_src    = 4'd8;
    req_dst    = 4'd9;
    req_amount = 10'd50;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_req_ready", int'(req_ready), 1);
    check("abort_resp_valid", int'(resp_valid), 0);
    check("abort_txn_count", int'(txn_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_txn_count_post", int'(txn_count), model_cnt);
    run_txn(0, 8, 0, 0, 0);
    run_txn(0, 9, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
